// File: rtl/pc_gen_pkg.sv
// pc_gen shared types: FSM states, next-PC select, default widths.
// Used by pc_gen (optional RAS via PC_GEN_RAS_EN), pc_ras and pc_gen_if.
package pc_pkg;

  localparam int PC_XLEN        = 32;
  localparam int PC_INSTR_BYTES = 4;
  localparam int PC_RAS_DEPTH   = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_t;

  typedef enum logic [2:0] {
    TRAP,
    REDIR,
    HOLD,
    RAS,
    SEQ
  } pc_sel_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-address bundle between pc_gen (master) and the core/fetch side (slave).
// call/ret/ras_underflow are only meaningful when PC_GEN_RAS_EN is defined.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN = PC_XLEN
);

  logic            fetch_ready;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            halt;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            misalign_err;
  logic            ras_underflow;

  modport master (
    input  fetch_ready,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  trap_valid,
    input  trap_vector,
    input  halt,
    input  call,
    input  ret,
    output pc_out,
    output pc_valid,
    output misalign_err,
    output ras_underflow
  );

  modport slave (
    output fetch_ready,
    output stall,
    output redirect_valid,
    output redirect_target,
    output trap_valid,
    output trap_vector,
    output halt,
    output call,
    output ret,
    input  pc_out,
    input  pc_valid,
    input  misalign_err,
    input  ras_underflow
  );

endinterface

// File: rtl/pc_gen_ras.sv
// pc_ras: circular return-address stack; a push when full drops the oldest.
// Instantiated by pc_gen only when PC_GEN_RAS_EN is defined.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = PC_XLEN,
  parameter int DEPTH = PC_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] pop_data,
  output logic            empty,
  output logic            full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top;
  logic [PW-1:0]   top_inc;
  logic [CW-1:0]   cnt;
  logic            pop_ok;

  assign top_inc  = top + 1'b1;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign pop_data = mem[top];
  assign pop_ok   = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          mem[top_inc] <= push_data;
          top          <= top_inc;
          if (!full) cnt <= cnt + 1'b1;
        end
        2'b01: begin
          top <= top - 1'b1;
          cnt <= cnt - 1'b1;
        end
        // pop then push lands on the same slot
        2'b11: mem[top] <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: registered fetch-address generator with stall/redirect/trap/halt.
// Define PC_GEN_RAS_EN to add return prediction through pc_ras.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = PC_INSTR_BYTES,
  parameter int              RAS_DEPTH    = PC_RAS_DEPTH
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);

  localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

  pc_state_t       state;
  pc_state_t       state_n;
  pc_sel_t         sel;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_n;
  logic            valid;
  logic            mis;
  logic            mis_n;
  logic            seq;
  logic            ret_en;
  logic            ras_empty;
  logic [XLEN-1:0] ras_data;

`ifdef PC_GEN_RAS_EN
  logic call_en;
  logic ras_full;
  logic und;

  assign call_en = bus.call;
  assign ret_en  = bus.ret;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (seq & call_en),
    .pop       (seq & ret_en),
    .flush     (sel == TRAP),
    .push_data (pc + STEP),
    .pop_data  (ras_data),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) und <= 1'b0;
    else      und <= seq & ret_en & ras_empty;
  end

  assign bus.ras_underflow = und;
`else
  assign ret_en            = 1'b0;
  assign ras_empty         = 1'b1;
  assign ras_data          = '0;
  assign bus.ras_underflow = 1'b0;
`endif

  always_comb begin
    sel     = HOLD;
    state_n = state;
    seq     = 1'b0;
    unique case (state)
      BOOT: begin
        if (!bus.halt) state_n = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          state_n = HALTED;
        end else begin
          priority case (1'b1)
            bus.trap_valid:     sel = TRAP;
            bus.redirect_valid: sel = REDIR;
            bus.stall:          sel = HOLD;
            !bus.fetch_ready:   sel = HOLD;
            default: begin
              seq = 1'b1;
              sel = (ret_en && !ras_empty) ? RAS : SEQ;
            end
          endcase
        end
      end
      HALTED: begin
        // only a trap may move the PC while halted
        if (bus.trap_valid) begin
          sel     = TRAP;
          state_n = RUN;
        end else if (!bus.halt) begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_comb begin
    pc_n  = pc;
    mis_n = 1'b0;
    unique case (sel)
      TRAP: begin
        pc_n  = bus.trap_vector & ~LOW_MASK;
        mis_n = |(bus.trap_vector & LOW_MASK);
      end
      REDIR: begin
        pc_n  = bus.redirect_target & ~LOW_MASK;
        mis_n = |(bus.redirect_target & LOW_MASK);
      end
      RAS:     pc_n = ras_data;
      SEQ:     pc_n = pc + STEP;
      default: pc_n = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      valid <= 1'b0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      valid <= (state_n == RUN);
      mis   <= mis_n;
    end
  end

  assign bus.pc_out       = pc;
  assign bus.pc_valid     = valid;
  assign bus.misalign_err = mis;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed bench for pc_gen against a queue-based reference.
// Covers the RAS scenarios too when PC_GEN_RAS_EN is defined.
module tb_pc_gen;

  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (4),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_boot;
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_und;
  logic [31:0] m_stack [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_boot = 1'b1;
    m_run  = 1'b0;
    m_pc   = RV;
    m_mis  = 1'b0;
    m_und  = 1'b0;
    m_stack.delete();
  endtask

  task automatic m_load(input logic [31:0] t);
    m_pc  = t & ~32'h3;
    m_mis = (t[1:0] != 2'b00);
  endtask

  task automatic m_step();
    logic [31:0] nxt;
    m_mis = 1'b0;
    m_und = 1'b0;
    if (m_boot) begin
      if (!bus.halt) begin
        m_boot = 1'b0;
        m_run  = 1'b1;
      end
    end else if (!m_run) begin
      if (bus.trap_valid) begin
        m_load(bus.trap_vector);
        m_stack.delete();
        m_run = 1'b1;
      end else if (!bus.halt) begin
        m_run = 1'b1;
      end
    end else if (bus.halt) begin
      m_run = 1'b0;
    end else if (bus.trap_valid) begin
      m_load(bus.trap_vector);
      m_stack.delete();
    end else if (bus.redirect_valid) begin
      m_load(bus.redirect_target);
    end else if (!bus.stall && bus.fetch_ready) begin
      nxt = m_pc + 32'd4;
      if (RAS_EN && bus.ret) begin
        if (m_stack.size() > 0) nxt = m_stack.pop_back();
        else m_und = 1'b1;
      end
      if (RAS_EN && bus.call) begin
        m_stack.push_back(m_pc + 32'd4);
        if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
      end
      m_pc = nxt;
    end
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    check("pc_out", bus.pc_out, m_pc);
    check("pc_valid", 32'(bus.pc_valid), 32'(m_run));
    check("misalign", 32'(bus.misalign_err), 32'(m_mis));
    check("underflow", 32'(bus.ras_underflow), 32'(m_und));
  endtask

  task automatic go(input bit fr = 1'b1, input bit st = 1'b0,
                    input bit rv = 1'b0, input logic [31:0] rt = '0,
                    input bit tv = 1'b0, input logic [31:0] tt = '0,
                    input bit h = 1'b0, input bit c = 1'b0,
                    input bit r = 1'b0);
    bus.fetch_ready     = fr;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.trap_valid      = tv;
    bus.trap_vector     = tt;
    bus.halt            = h;
    bus.call            = c;
    bus.ret             = r;
    cyc();
  endtask

  task automatic areset();
    #2;
    rst = 1'b0;
    #1;
    check("arst_pc", bus.pc_out, RV);
    check("arst_valid", 32'(bus.pc_valid), 32'd0);
    check("arst_mis", 32'(bus.misalign_err), 32'd0);
    check("arst_und", 32'(bus.ras_underflow), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] t1;
    logic [31:0] t2;
    bus.fetch_ready     = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.trap_valid      = 1'b0;
    bus.trap_vector     = '0;
    bus.halt            = 1'b0;
    bus.call            = 1'b0;
    bus.ret             = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc_out, RV);
    check("rst_valid", 32'(bus.pc_valid), 32'd0);
    check("rst_mis", 32'(bus.misalign_err), 32'd0);
    check("rst_und", 32'(bus.ras_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    go();
    check("boot_exit", bus.pc_out, 32'h100);
    go();
    check("seq1", bus.pc_out, 32'h104);
    go();
    check("seq2", bus.pc_out, 32'h108);

    go(.st(1'b1), .rv(1'b1), .rt(32'h2002));
    check("redir_pc", bus.pc_out, 32'h2000);
    check("redir_mis", 32'(bus.misalign_err), 32'd1);
    go();

    go(.tv(1'b1), .tt(32'h80), .rv(1'b1), .rt(32'h400));
    check("trap_prio", bus.pc_out, 32'h80);
    go(.h(1'b1));
    check("halt_valid", 32'(bus.pc_valid), 32'd0);
    go(.h(1'b1), .fr(1'b1));
    check("halt_hold", bus.pc_out, 32'h80);
    go(.h(1'b1), .tv(1'b1), .tt(32'h300));
    check("halt_trap", bus.pc_out, 32'h300);
    go();

    go(.rv(1'b1), .rt(32'hFFFF_FFF8));
    go();
    check("wrap0", bus.pc_out, 32'hFFFF_FFFC);
    go();
    check("wrap1", bus.pc_out, 32'h0);
    go();
    check("wrap2", bus.pc_out, 32'h4);

`ifdef PC_GEN_RAS_EN
    go(.rv(1'b1), .rt(32'h10));
    go(.c(1'b1));
    go(.rv(1'b1), .rt(32'h50));
    go(.c(1'b1));
    go(.r(1'b1));
    check("ret1", bus.pc_out, 32'h54);
    go(.r(1'b1));
    check("ret2", bus.pc_out, 32'h14);
    go(.r(1'b1));
    check("ret3", bus.pc_out, 32'h18);
    check("ret3_und", 32'(bus.ras_underflow), 32'd1);

    for (int i = 0; i < 5; i++) begin
      go(.rv(1'b1), .rt(32'(i * 16)));
      go(.c(1'b1));
    end
    go(.r(1'b1));
    check("ovf_ret0", bus.pc_out, 32'h44);
    go(.r(1'b1));
    check("ovf_ret1", bus.pc_out, 32'h34);
    go(.r(1'b1));
    check("ovf_ret2", bus.pc_out, 32'h24);
    go(.r(1'b1));
    check("ovf_ret3", bus.pc_out, 32'h14);
    go(.r(1'b1));
    check("ovf_und", 32'(bus.ras_underflow), 32'd1);
`endif

    go(.rv(1'b1), .rt(32'h1003));
    areset();

    for (int n = 0; n < 800; n++) begin
      t1 = $urandom;
      t2 = $urandom;
      if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) t2[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) t1 = t1 & 32'h0000_00FC;
      go(.fr($urandom_range(0, 9) < 8),
         .st($urandom_range(0, 9) < 2),
         .rv($urandom_range(0, 9) == 0),
         .rt(t1),
         .tv($urandom_range(0, 29) == 0),
         .tt(t2),
         .h($urandom_range(0, 11) == 0),
         .c($urandom_range(0, 5) == 0),
         .r($urandom_range(0, 5) == 0));
      if (n == 400) areset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator feeding the fetch stage of the MiniMicro core. Produces a registered fetch address with a valid/ready handshake toward instruction memory. Accepts stall, branch/jump redirect, trap-vector and halt requests with fixed priority. Optionally predicts returns through a small return-address stack.

## Interface
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, `pc_out` value after reset; must be `INSTR_BYTES`-aligned.
- INSTR_BYTES, 4, sequential increment and alignment granule; power of two.
- RAS_DEPTH, 4, return-address-stack entries (only with `PC_GEN_RAS_EN`); power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_ready  in  1  fetch stage accepts `pc_out` this cycle.
- stall  in  1  hold `pc_out` regardless of `fetch_ready`.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  redirect destination.
- trap_valid  in  1  exception/interrupt entry.
- trap_vector  in  XLEN  trap destination.
- halt  in  1  stop issuing; level-sensitive.
- call  in  1  current `pc_out` is a call; push return address (RAS build only).
- ret  in  1  current `pc_out` is a return; pop prediction (RAS build only).
- pc_out  out  XLEN  current fetch address.
- pc_valid  out  1  `pc_out` is a valid request.
- misalign_err  out  1  one-cycle pulse: redirect/trap target was misaligned.
- ras_underflow  out  1  one-cycle pulse: `ret` with empty stack.

## Operation
- States (`pc_state_t`): BOOT, RUN, HALTED.
- BOOT: entered on reset; `pc_valid`=0; moves to RUN on the first clock edge with `halt`=0.
- RUN: `pc_valid`=1. Moves to HALTED when `halt`=1; `pc_out` is frozen.
- HALTED: `pc_valid`=0. Returns to RUN when `halt`=0 or when `trap_valid`=1; a trap loads its vector.
- Next-PC priority, highest first:
  - `trap_valid`: load `trap_vector`.
  - `redirect_valid`: load `redirect_target`.
  - `stall`: hold.
  - `fetch_ready`=0: hold.
  - `ret` with stack non-empty: load the popped entry.
  - Otherwise: `pc_out`+`INSTR_BYTES`.
- Trap and redirect override stall and `fetch_ready`.
- Address rules:
  - Arithmetic is modulo 2^XLEN; wrap from all-ones-minus-step to 0 is silent.
  - Targets have their low log2(`INSTR_BYTES`) bits forced to 0. If any were set, `misalign_err` pulses on the following cycle.
- `call` and `ret` act only when the sequential path is taken, i.e. an accept with no trap or redirect.
  - On `call`, `pc_out`+`INSTR_BYTES` is pushed. When the stack is full, the oldest entry is overwritten (circular).
  - `ret` with an empty stack falls back to sequential increment and pulses `ras_underflow`.
  - Simultaneous `call`+`ret`: pop then push; the net count is unchanged.
- A trap flushes the RAS to empty.

## Timing
- All outputs are registered.
- A request sampled at edge N is visible on `pc_out` after edge N.
- Redirect/trap latency: 1 cycle.
- Handshake:
  - A fetch is accepted when `pc_valid`&`fetch_ready`&!`stall`.
  - `pc_out` is stable while `pc_valid`=1 and the fetch is not accepted.
- Reset values: `pc_out`=RESET_VECTOR, `pc_valid`=0, `misalign_err`=0, `ras_underflow`=0, state=BOOT, RAS empty.
- Reset asserted mid-operation clears everything immediately (asynchronously), including pending pulses. Deassertion is used synchronously.

## Configuration
- `PC_GEN_RAS_EN` defined:
  - The RAS is instantiated.
  - `call`/`ret` behave as described above.
- `PC_GEN_RAS_EN` undefined:
  - No RAS storage exists.
  - `call`/`ret` are ignored, and `ret` takes the sequential path.
  - `ras_underflow` is tied to 0.
  - `RAS_DEPTH` is unused.

## Structure
- Package `pc_pkg` holds:
  - `pc_state_t` (BOOT, RUN, HALTED).
  - The next-PC select enum `pc_sel_t` (TRAP, REDIR, HOLD, RAS, SEQ).
  - Default constants for XLEN and INSTR_BYTES.
- Sub-module `pc_ras` is the circular return-address stack.
  - Ports: push/pop/flush, push data, pop data, empty, full.
  - Instantiated only under `PC_GEN_RAS_EN`.

## Test plan
- Reset with RESET_VECTOR=0x100, then release with `fetch_ready`=1 → BOOT for 1 cycle, then `pc_out` = 0x100, 0x104, 0x108 with `pc_valid`=1.
- At `pc_out`=0x108, assert `stall` and `redirect_valid`=1 with target 0x2002 → next `pc_out`=0x2000; `misalign_err` pulses once.
- Assert `trap_valid`(0x80) and `redirect_valid`(0x400) in the same cycle → `pc_out`=0x80. Apply `halt` → `pc_valid`=0 and `pc_out` held. A trap while halted resumes at the vector.
- Start at `pc_out`=0xFFFFFFF8 (XLEN=32) → sequence 0xFFFFFFFC, 0x0, 0x4.
- RAS build, RAS_DEPTH=4:
  - Call at 0x10 → pushes 0x14.
  - Call at 0x50 → pushes 0x54.
  - `ret` twice → `pc_out` 0x54, then 0x14.
  - Third `ret` → sequential increment and `ras_underflow` pulse.
- RAS build: five calls at 0x0, 0x10, 0x20, 0x30, 0x40, then four `ret`s → 0x44, 0x34, 0x24, 0x14. The oldest entry (0x4) was overwritten.
